// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchronizer followed by a counter-qualified
// level FSM. Publishes a clean level, single-cycle edge pulses and a
// saturating count of transitions that were abandoned before qualifying.
module debounce_sync #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       din,
   input  logic       glitch_clr,
   output logic       dout,
   output logic       rise,
   output logic       fall,
   output logic       busy,
   output logic [7:0] glitch_cnt
);

   typedef enum logic [1:0] {
      S_LOW    = 2'd0,
      S_WAIT_H = 2'd1,
      S_HIGH   = 2'd2,
      S_WAIT_L = 2'd3
   } state_t;

   // Last count value before a transition is accepted on the next sample.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             dout_nxt;
   logic             rise_nxt;
   logic             fall_nxt;
   logic             abort;

   // Two-flop synchronizer; only sync2 is allowed to reach the FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // State register together with the counter and the registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_LOW;
         cnt   <= '0;
         dout  <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         dout  <= dout_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
      end
   end

   // Next-state logic: qualify a new level for DEBOUNCE_CYCLES samples,
   // abort back to the stable state on the first reverting sample.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dout_nxt  = dout;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      abort     = 1'b0;
      case (state)
         S_LOW: begin
            if (sync2) begin
               state_nxt = S_WAIT_H;
               cnt_nxt   = CNT_W'(1);
            end
         end
         S_WAIT_H: begin
            if (sync2) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = S_HIGH;
                  cnt_nxt   = '0;
                  dout_nxt  = 1'b1;
                  rise_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end else begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
               abort     = 1'b1;
            end
         end
         S_HIGH: begin
            if (!sync2) begin
               state_nxt = S_WAIT_L;
               cnt_nxt   = CNT_W'(1);
            end
         end
         S_WAIT_L: begin
            if (!sync2) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = S_LOW;
                  cnt_nxt   = '0;
                  dout_nxt  = 1'b0;
                  fall_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end else begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
               abort     = 1'b1;
            end
         end
         default: begin
            state_nxt = S_LOW;
            cnt_nxt   = '0;
            dout_nxt  = 1'b0;
         end
      endcase
   end

   // Output decode: busy comes straight from the state register only.
   always_comb begin
      busy = (state == S_WAIT_H) || (state == S_WAIT_L);
   end

   // Glitch counter: clear has priority over a same-edge abort; saturates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         glitch_cnt <= 8'd0;
      end else if (glitch_clr) begin
         glitch_cnt <= 8'd0;
      end else if (abort && (glitch_cnt != 8'hFF)) begin
         glitch_cnt <= glitch_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync with DEBOUNCE_CYCLES=4. A run-length model of the
// debouncer is advanced once per clock edge; one compare process checks
// every output against it on the falling edge, and directed scenarios add
// literal expectations at known edge offsets.
module tb_debounce_sync;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       din = 1'b0;
   logic       glitch_clr = 1'b0;
   logic       dout;
   logic       rise;
   logic       fall;
   logic       busy;
   logic [7:0] glitch_cnt;
   logic       dq;

   int checks = 0;
   int failures = 0;

   // model state
   logic m_s1 = 1'b0, m_s2 = 1'b0, m_dout = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_dq = 1'b0;
   int   m_run = 0;
   int   m_g = 0;
   bit   cmp_en = 1'b0;
   int   n_rise = 0, n_fall = 0, n_dq_tr = 0;
   logic dq_prev = 1'b0;

   debounce_sync #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .glitch_clr(glitch_clr),
      .dout(dout), .rise(rise), .fall(fall), .busy(busy), .glitch_cnt(glitch_cnt)
   );

   // downstream d_ff sharing clk/rst_n
   always @(posedge clk) begin
      if (!rst_n) dq <= 1'b0;
      else        dq <= dout;
   end

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then advance the model across that edge.
   task automatic tick(input logic d, input logic clr, input logic r);
      bit ab;
      #1;
      din = d; glitch_clr = clr; rst_n = r;
      @(posedge clk);
      if (!r) begin
         m_s1 = 0; m_s2 = 0; m_dout = 0; m_rise = 0; m_fall = 0;
         m_run = 0; m_g = 0; m_dq = 0;
      end else begin
         m_dq = m_dout;
         m_rise = 0; m_fall = 0; ab = 0;
         if (m_s2 != m_dout) begin
            m_run++;
            if (m_run == D) begin
               m_dout = ~m_dout;
               if (m_dout) m_rise = 1; else m_fall = 1;
               m_run = 0;
            end
         end else begin
            if (m_run > 0) ab = 1;
            m_run = 0;
         end
         if (clr) m_g = 0;
         else if (ab && m_g < 255) m_g++;
         m_s2 = m_s1;
         m_s1 = d;
      end
   endtask

   // Compare process: every output against the model on every cycle.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("dout", 32'(dout), 32'(m_dout));
         check("rise", 32'(rise), 32'(m_rise));
         check("fall", 32'(fall), 32'(m_fall));
         check("busy", 32'(busy), 32'(m_run > 0));
         check("glitch_cnt", 32'(glitch_cnt), 32'(m_g));
         check("dff_q", 32'(dq), 32'(m_dq));
         check("rise_fall_excl", 32'(rise & fall), 32'd0);
         if (rise === 1'b1) n_rise++;
         if (fall === 1'b1) n_fall++;
         if (dq !== dq_prev) n_dq_tr++;
         dq_prev = dq;
      end
   end

   initial begin
      int r0, f0, t0, len;
      logic lvl;

      // 1: reset with din held high, then release
      for (int k = 0; k < 5; k++) begin
         tick(1, 0, 0);
         cmp_en = 1'b1;
         #2;
         check("rst_dout", 32'(dout), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_pulses", 32'(rise | fall), 32'd0);
         check("rst_glitch", 32'(glitch_cnt), 32'd0);
      end
      r0 = n_rise;
      for (int k = 1; k <= 12; k++) begin
         tick(1, 0, 1);
         #2;
         if (k == 5) check("rel_rise_early", 32'(rise), 32'd0);
         if (k == 6) check("rel_rise_edge", 32'(rise), 32'd1);
      end
      #5;
      check("rel_rise_count", 32'(n_rise - r0), 32'd1);

      // 2: clean fall then clean rise
      f0 = n_fall;
      for (int k = 0; k < 10; k++) begin
         tick(0, 0, 1);
         #2;
         if (k == 1) check("fall_busy_pre", 32'(busy), 32'd0);
         if (k >= 2 && k <= 4) check("fall_busy", 32'(busy), 32'd1);
         if (k == 4) check("fall_dout_pre", 32'(dout), 32'd1);
         if (k == 5) begin
            check("fall_dout", 32'(dout), 32'd0);
            check("fall_pulse", 32'(fall), 32'd1);
            check("fall_busy_post", 32'(busy), 32'd0);
         end
         if (k == 6) check("fall_pulse_end", 32'(fall), 32'd0);
      end
      #5;
      check("fall_count", 32'(n_fall - f0), 32'd1);
      for (int k = 0; k < 10; k++) begin
         tick(1, 0, 1);
         #2;
         if (k >= 2 && k <= 4) check("rise_busy", 32'(busy), 32'd1);
         if (k == 5) begin
            check("rise_dout", 32'(dout), 32'd1);
            check("rise_pulse", 32'(rise), 32'd1);
         end
         if (k == 6) check("rise_pulse_end", 32'(rise), 32'd0);
      end
      check("clean_glitch", 32'(glitch_cnt), 32'd0);
      for (int k = 0; k < 10; k++) tick(0, 0, 1);

      // 3: glitch rejection and saturation
      r0 = n_rise;
      tick(1, 0, 1); tick(1, 0, 1);
      for (int k = 0; k < 6; k++) tick(0, 0, 1);
      #2;
      check("glitch_one", 32'(glitch_cnt), 32'd1);
      check("glitch_dout", 32'(dout), 32'd0);
      check("glitch_no_rise", 32'(n_rise - r0), 32'd0);
      for (int n = 0; n < 300; n++) begin
         tick(1, 0, 1); tick(1, 0, 1);
         for (int k = 0; k < 4; k++) tick(0, 0, 1);
      end
      #2;
      check("glitch_sat", 32'(glitch_cnt), 32'd255);

      // 4: clear coinciding with an abort
      tick(0, 1, 1);
      for (int n = 0; n < 7; n++) begin
         tick(1, 0, 1); tick(1, 0, 1);
         for (int k = 0; k < 4; k++) tick(0, 0, 1);
      end
      #2;
      check("glitch_seven", 32'(glitch_cnt), 32'd7);
      tick(1, 0, 1); tick(1, 0, 1); tick(0, 0, 1); tick(0, 0, 1);
      #2;
      check("pre_abort_busy", 32'(busy), 32'd1);
      tick(0, 1, 1);
      #2;
      check("clr_wins", 32'(glitch_cnt), 32'd0);
      check("clr_abort_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 4; k++) tick(0, 0, 1);

      // 5: reset during qualification
      r0 = n_rise;
      tick(1, 0, 1); tick(1, 0, 1); tick(1, 0, 1);
      #2;
      check("midq_busy", 32'(busy), 32'd1);
      tick(0, 0, 0); tick(0, 0, 0);
      #2;
      check("midq_busy_rst", 32'(busy), 32'd0);
      check("midq_dout", 32'(dout), 32'd0);
      for (int k = 0; k < 10; k++) tick(0, 0, 1);
      #2;
      check("midq_no_rise", 32'(n_rise - r0), 32'd0);
      check("midq_glitch", 32'(glitch_cnt), 32'd0);

      // 6: bouncy input into the downstream flop
      t0 = n_dq_tr;
      r0 = n_rise;
      tick(1, 0, 1); tick(0, 0, 1); tick(1, 0, 1);
      tick(1, 0, 1); tick(0, 0, 1); tick(1, 0, 1);
      for (int k = 0; k < 14; k++) tick(1, 0, 1);
      #5;
      check("dff_transitions", 32'(n_dq_tr - t0), 32'd1);
      check("bouncy_rise", 32'(n_rise - r0), 32'd1);
      check("dff_q_high", 32'(dq), 32'd1);

      // random runs with occasional clear and reset
      lvl = 1'b1;
      for (int n = 0; n < 400; n++) begin
         lvl = ~lvl;
         len = $urandom_range(1, 7);
         for (int j = 0; j < len; j++)
            tick(lvl, ($urandom_range(0, 31) == 0), ($urandom_range(0, 299) != 0));
      end
      for (int k = 0; k < 10; k++) tick(lvl, 0, 1);

      #5;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
